// File: rtl/cla_pkg.sv
// Shared defaults, operation encoding and sizing helper for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int group_count(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group_lookahead.sv
// Second-level lookahead: every group carry is formed as a flat sum of products of the
// group propagate/generate terms and the carry in, so no carry ripples between groups.
module cla_group_lookahead #(
  parameter int NGROUPS = 8
) (
  input  logic [NGROUPS-1:0] grp_p,
  input  logic [NGROUPS-1:0] grp_g,
  input  logic               c_in,
  output logic [NGROUPS:0]   grp_c
);

  // AND of v[hi:lo]; an empty span yields 1
  function automatic logic span_and(input logic [NGROUPS-1:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      r = r & v[i];
    end
    return r;
  endfunction

  // C[k+1] = G[k] | P[k]G[k-1] | ... | P[k..0]c_in
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int k = 0; k < NGROUPS; k++) begin
      grp_c[k+1] = c_in & span_and(grp_p, 0, k);
      for (int j = 0; j <= k; j++) begin
        grp_c[k+1] = grp_c[k+1] | (grp_g[j] & span_and(grp_p, j + 1, k));
      end
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Three-stage pipelined two-level carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_FLAGS_EN to compute and register overflow/zero; otherwise both are tied to 0.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = group_count(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  logic             advance, ld1_s, ld2_s, ld3_s;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] b_eff_s, p_s, g_s;
  logic [NG-1:0]    gp_s, gg_s;
  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic [NG-1:0]    gp1_q, gp1_d, gg1_q, gg1_d;
  logic             cin1_q, cin1_d;
  logic [NG:0]      cg_s, cg2_q, cg2_d;
  logic [WIDTH-1:0] p2_q, p2_d, g2_q, g2_d;
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s, sum_q, sum_d;
  logic             c_out_q, c_out_d;

  // One global stall: every stage moves together, bubbles included
  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ld1_s     = advance && in_valid;
  assign ld2_s     = advance && v1_q;
  assign ld3_s     = advance && v2_q;

  // S1: bit and group propagate/generate from the (possibly inverted) operands
  always_comb begin
    b_eff_s = (sub == OP_SUB) ? ~b : b;
    p_s     = a ^ b_eff_s;
    g_s     = a & b_eff_s;
    gp_s    = '1;
    gg_s    = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gg_s[k] = g_s[k*GROUP+j] | (p_s[k*GROUP+j] & gg_s[k]);
        gp_s[k] = gp_s[k] & p_s[k*GROUP+j];
      end
    end
  end

  cla_group_lookahead #(
    .NGROUPS (NG)
  ) u_lookahead (
    .grp_p (gp1_q),
    .grp_g (gg1_q),
    .c_in  (cin1_q),
    .grp_c (cg_s)
  );

  // S3: each group restarts from its lookahead carry; only in-group carries ripple
  always_comb begin
    c_s    = '0;
    c_s[0] = cg2_q[0];
    for (int i = 0; i < WIDTH; i++) begin
      if (((i + 1) % GROUP) == 0) begin
        c_s[i+1] = cg2_q[(i+1)/GROUP];
      end else begin
        c_s[i+1] = g2_q[i] | (p2_q[i] & c_s[i]);
      end
    end
    sum_s = p2_q ^ c_s[WIDTH-1:0];
  end

  // Next-state: valids shift on advance, data loads only behind a valid
  always_comb begin
    v1_d    = advance ? in_valid : v1_q;
    v2_d    = advance ? v1_q : v2_q;
    v3_d    = advance ? v2_q : v3_q;
    p1_d    = ld1_s ? p_s : p1_q;
    g1_d    = ld1_s ? g_s : g1_q;
    gp1_d   = ld1_s ? gp_s : gp1_q;
    gg1_d   = ld1_s ? gg_s : gg1_q;
    cin1_d  = ld1_s ? ((sub == OP_SUB) ? 1'b1 : c_in) : cin1_q;
    p2_d    = ld2_s ? p1_q : p2_q;
    g2_d    = ld2_s ? g1_q : g2_q;
    cg2_d   = ld2_s ? cg_s : cg2_q;
    sum_d   = ld3_s ? sum_s : sum_q;
    c_out_d = ld3_s ? c_s[WIDTH] : c_out_q;
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p1_q    <= '0;
      g1_q    <= '0;
      gp1_q   <= '0;
      gg1_q   <= '0;
      cin1_q  <= 1'b0;
      p2_q    <= '0;
      g2_q    <= '0;
      cg2_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      gp1_q   <= gp1_d;
      gg1_q   <= gg1_d;
      cin1_q  <= cin1_d;
      p2_q    <= p2_d;
      g2_q    <= g2_d;
      cg2_q   <= cg2_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef CLA_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d;

  // Signed overflow is the carry into the MSB differing from the carry out of it
  always_comb begin
    ovf_d  = ld3_s ? (c_s[WIDTH] ^ c_s[WIDTH-1]) : ovf_q;
    zero_d = ld3_s ? (sum_s == '0) : zero_q;
  end

  // Flag registers ride alongside the S3 result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a 32/4 instance and a 16/8 instance on one clock.
module tb_pipelined_cla_adder;

`ifdef CLA_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, overflow, zero;
  logic [31:0] a, b, sum;
  logic        in_valid_w, in_ready_w, sub_w, c_in_w, out_valid_w, out_ready_w;
  logic        c_out_w, overflow_w, zero_w;
  logic [15:0] a_w, b_w, sum_w;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .overflow(overflow), .zero(zero)
  );

  pipelined_cla_adder #(.WIDTH(16), .GROUP(8)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
    .sub(sub_w), .c_in(c_in_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .sum(sum_w),
    .c_out(c_out_w), .overflow(overflow_w), .zero(zero_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic s, input logic ci);
    if (w16) begin
      in_valid_w = v; a_w = av[15:0]; b_w = bv[15:0]; sub_w = s; c_in_w = ci;
    end else begin
      in_valid = v; a = av; b = bv; sub = s; c_in = ci;
    end
  endtask

  task automatic check_out(input string tag, input bit w16, input logic ev, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
    if (w16) begin
      chk({tag, "/valid"}, out_valid_w, ev);
      if (ev) begin
        chk({tag, "/sum"}, sum_w, es[15:0]);
        chk({tag, "/c_out"}, c_out_w, ec);
        chk({tag, "/ovf"}, overflow_w, eo);
        chk({tag, "/zero"}, zero_w, ez);
      end
    end else begin
      chk({tag, "/valid"}, out_valid, ev);
      if (ev) begin
        chk({tag, "/sum"}, sum, es);
        chk({tag, "/c_out"}, c_out, ec);
        chk({tag, "/ovf"}, overflow, eo);
        chk({tag, "/zero"}, zero, ez);
      end
    end
  endtask

  // Operands i and 2i back to back; result 3i must leave on consecutive cycles
  task automatic stream(input bit w16);
    for (int c = 0; c < 13; c++) begin
      check_out($sformatf("stream%0d_c%0d", w16, c), w16, (c >= 3), 32'(3 * (c - 3)),
                1'b0, 1'b0, FL && (c == 3));
      if (c < 10) drive(w16, 1'b1, 32'(c), 32'(2 * c), 1'b0, 1'b0);
      else        drive(w16, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      chk($sformatf("stream%0d_in_ready_c%0d", w16, c), w16 ? in_ready_w : in_ready, 1'b1);
      @(negedge clk);
    end
    check_out($sformatf("stream%0d_drained", w16), w16, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; out_ready_w = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst/out_valid", out_valid, 1'b0);
    chk("rst/in_ready", in_ready, 1'b1);
    chk("rst/sum", sum, 32'd0);
    chk("rst/c_out", c_out, 1'b0);
    chk("rst/ovf", overflow, 1'b0);
    chk("rst/zero", zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // FFFFFFFF + 1 wraps to zero with carry out
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    #1 chk("wrap/in_ready", in_ready, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("wrap/lat1", out_valid, 1'b0);
    @(negedge clk); chk("wrap/lat2", out_valid, 1'b0);
    @(negedge clk); check_out("wrap", 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FL);
    @(negedge clk); chk("wrap/after", out_valid, 1'b0);

    // Subtraction: signed overflow, then a borrow (c_in must be ignored)
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); check_out("sub_ovf", 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, FL, 1'b0);
    @(negedge clk); check_out("sub_borrow", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("sub/after", out_valid, 1'b0);

    stream(1'b0);

    // Fill, stall for 4 cycles with an operand waiting, then drain in order
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'(100 + k), 32'(k), 1'b0, 1'b0);
      @(negedge clk);
    end
    check_out("stall_first", 1'b0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'd103, 32'd3, 1'b0, 1'b0);
    #1 chk("stall/in_ready", in_ready, 1'b0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check_out($sformatf("stall_hold%0d", s), 1'b0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
      chk($sformatf("stall_hold%0d/in_ready", s), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("stall/release_in_ready", in_ready, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_out("drain1", 1'b0, 1'b1, 32'd102, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check_out("drain2", 1'b0, 1'b1, 32'd104, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check_out("drain3", 1'b0, 1'b1, 32'd106, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("drain/empty", out_valid, 1'b0);

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'(k + 1), 32'd10, 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_out("pre_reset", 1'b0, 1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_reset/out_valid", out_valid, 1'b0);
    chk("mid_reset/sum", sum, 32'd0);
    chk("mid_reset/in_ready", in_ready, 1'b1);
    @(negedge clk); reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", s), out_valid, 1'b0);
    end

    // 16-bit / 8-bit group instance
    drive(1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); check_out("w16_wrap", 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FL);
    @(negedge clk); chk("w16_wrap/after", out_valid_w, 1'b0);
    stream(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
